// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and helpers for the convolution window generator.
package conv_window_gen_pkg;

    localparam int unsigned DWIDTH_DAT_DEF = 12;
    localparam int unsigned SLICE_DEF      = 3;
    localparam int unsigned IMG_W_DEF      = 640;
    localparam int unsigned IMG_H_DEF      = 480;

    // RGB444 pixel layout: R[11:8] G[7:4] B[3:0]
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Counter width able to hold 0..n-1, never below 1 bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-line delay: addressed by column, so the word read at a column is the pixel
// written at the same column one accepted line earlier.
module conv_line_buffer #(
    parameter int unsigned DWIDTH = 12,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_din,
    output logic [DWIDTH-1:0] o_dout
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Read returns the old contents; the write only lands at the clock edge
    assign o_dout = r_mem[i_addr];

    // Shift in the new pixel only when the stream accepts one
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to packed SLICE x SLICE windows for the ALU din bus.
// Optional SOF checker compiled in with `define CONV_WINDOW_SOF_CHECK_EN.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned DWIDTH_DAT = DWIDTH_DAT_DEF,
    parameter int unsigned SLICE      = SLICE_DEF,
    parameter int unsigned IMG_W      = IMG_W_DEF,
    parameter int unsigned IMG_H      = IMG_H_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DWIDTH_DAT-1:0]             pix_in,
    input  logic                              pix_sof,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    output logic [SLICE*SLICE*DWIDTH_DAT-1:0] win_out,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic                              frame_done,
    output logic                              sof_err
);

    localparam int unsigned CW = cnt_width(IMG_W);
    localparam int unsigned RW = cnt_width(IMG_H);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col_eff;
    logic [RW-1:0] w_row_eff;
    logic          w_acc;
    logic          w_resync;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_produce;

    logic                              r_win_valid;
    logic [SLICE*SLICE*DWIDTH_DAT-1:0] r_win_out;
    logic                              r_frame_done;

    // w_tap[k] is the pixel k lines above the current one, same column
    logic [DWIDTH_DAT-1:0] w_tap  [SLICE];
    logic [DWIDTH_DAT-1:0] r_hist [SLICE][SLICE-1];
    logic [DWIDTH_DAT-1:0] w_win  [SLICE][SLICE];
    logic [SLICE*SLICE*DWIDTH_DAT-1:0] w_win_pack;

    assign pix_ready = !r_win_valid || win_ready;
    assign w_acc     = pix_valid && pix_ready;

`ifdef CONV_WINDOW_SOF_CHECK_EN
    logic r_sof_err;
    assign w_resync = pix_sof && ((r_row != '0) || (r_col != '0));
    assign sof_err  = r_sof_err;

    // Flag an SOF that arrives anywhere but the expected frame origin
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sof_err <= 1'b0;
        end else begin
            r_sof_err <= w_acc && w_resync;
        end
    end
`else
    logic w_unused_sof;
    assign w_unused_sof = pix_sof;
    assign w_resync     = 1'b0;
    assign sof_err      = 1'b0;
`endif

    // A resynchronising SOF makes the current pixel the frame origin
    assign w_col_eff  = w_resync ? '0 : r_col;
    assign w_row_eff  = w_resync ? '0 : r_row;
    assign w_col_last = (w_col_eff == CW'(IMG_W - 1));
    assign w_row_last = (w_row_eff == RW'(IMG_H - 1));
    assign w_produce  = (w_row_eff >= RW'(SLICE - 1)) && (w_col_eff >= CW'(SLICE - 1));

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row_eff + RW'(1);
            end else begin
                r_col <= w_col_eff + CW'(1);
                r_row <= w_row_eff;
            end
        end
    end

    assign w_tap[0] = pix_in;

    for (genvar k = 0; k < SLICE - 1; k++) begin : g_lb
        conv_line_buffer #(
            .DWIDTH (DWIDTH_DAT),
            .DEPTH  (IMG_W),
            .AWIDTH (CW)
        ) u_lb (
            .clk    (clk),
            .i_we   (w_acc),
            .i_addr (w_col_eff),
            .i_din  (w_tap[k]),
            .o_dout (w_tap[k+1])
        );
    end

    // Window as seen with the incoming column appended; row 0 is the oldest line
    always_comb begin
        for (int r = 0; r < SLICE; r++) begin
            for (int c = 0; c < SLICE - 1; c++) begin
                w_win[r][c] = r_hist[r][c];
            end
            w_win[r][SLICE-1] = w_tap[SLICE-1-r];
        end
    end

    // Flatten: element r*SLICE+c sits at bit offset DWIDTH_DAT*(r*SLICE+c)
    always_comb begin
        w_win_pack = '0;
        for (int r = 0; r < SLICE; r++) begin
            for (int c = 0; c < SLICE; c++) begin
                w_win_pack[DWIDTH_DAT*(r*SLICE+c) +: DWIDTH_DAT] = w_win[r][c];
            end
        end
    end

    // Keep the newest SLICE-1 columns; stale contents are masked by the output rule
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int r = 0; r < SLICE; r++) begin
                for (int c = 0; c < SLICE - 1; c++) begin
                    r_hist[r][c] <= w_win[r][c+1];
                end
            end
        end
    end

    // Output register: load on a producing accept, otherwise drain when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_win_out    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_acc && w_row_last && w_col_last;
            if (w_acc && w_produce) begin
                r_win_valid <= 1'b1;
                r_win_out   <= w_win_pack;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign win_out    = r_win_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on an 8x6 image with 3x3 windows.
module tb_conv_window_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int S  = 3;
    localparam int DW = 12;
    localparam int WW = S * S * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix_in;
    logic          pix_sof;
    logic          pix_valid;
    logic          pix_ready;
    logic [WW-1:0] win_out;
    logic          win_valid;
    logic          win_ready;
    logic          frame_done;
    logic          sof_err;

    conv_window_gen #(
        .DWIDTH_DAT (DW),
        .SLICE      (S),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame image indexed by raster position
    logic [DW-1:0] img [H][W];
    int            m_row;
    int            m_col;
    logic          m_valid;
    logic [WW-1:0] m_win;
    int            win_seen;
    int            fd_seen;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Window whose top-left pixel value is base, for pixel value = row*W+col
    function automatic logic [WW-1:0] win_of(input int base);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < S * S; i++) begin
            v[DW*i +: DW] = DW'(base + (i / S) * W + (i % S));
        end
        return v;
    endfunction

    // One clock: drive at negedge, check ready, step model, check outputs after the edge
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic sof,
                        input logic rdy);
        logic          acc;
        logic          prod;
        logic          n_fd;
        logic          n_se;
        logic [WW-1:0] nw;
        int            r;
        int            c;
        pix_valid = v;
        pix_in    = d;
        pix_sof   = sof;
        win_ready = rdy;
        #1;
        check_eq("pix_ready", pix_ready, !m_valid || rdy);
        acc  = v && (!m_valid || rdy);
        prod = 1'b0;
        n_fd = 1'b0;
        n_se = 1'b0;
        nw   = '0;
        if (acc) begin
            r = m_row;
            c = m_col;
`ifdef CONV_WINDOW_SOF_CHECK_EN
            if (sof && (r != 0 || c != 0)) begin
                r    = 0;
                c    = 0;
                n_se = 1'b1;
            end
`endif
            img[r][c] = d;
            if (r >= S - 1 && c >= S - 1) begin
                prod = 1'b1;
                for (int i = 0; i < S * S; i++) begin
                    nw[DW*i +: DW] = img[r-(S-1)+i/S][c-(S-1)+i%S];
                end
            end
            n_fd = (r == H - 1) && (c == W - 1);
            c++;
            if (c == W) begin
                c = 0;
                r++;
                if (r == H) r = 0;
            end
            m_row = r;
            m_col = c;
        end
        if (prod) begin
            m_valid = 1'b1;
            m_win   = nw;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("win_valid", win_valid, m_valid);
        if (m_valid) check_eq("win_out", win_out, m_win);
        check_eq("frame_done", frame_done, n_fd);
        check_eq("sof_err", sof_err, n_se);
        if (win_valid) win_seen++;
        if (frame_done) fd_seen++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_pix_ready", pix_ready, 1);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_sof_err", sof_err, 0);
        check_eq("rst_win_out", win_out, 0);
        @(negedge clk);
        rst     = 1'b0;
        m_row   = 0;
        m_col   = 0;
        m_valid = 1'b0;
        m_win   = '0;
    endtask

    // Pixels first..last of a frame at full rate, value = base + raster index
    task automatic send_run(input int first, input int last, input int base);
        for (int p = first; p <= last; p++) begin
            tick(1'b1, DW'(base + p), (p == 0), 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_in    = '0;
        pix_sof   = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        m_row     = 0;
        m_col     = 0;
        m_valid   = 1'b0;
        m_win     = '0;
        win_seen  = 0;
        fd_seen   = 0;
        @(negedge clk);
        do_reset();

        // Full frame with the sink always ready
        win_seen = 0;
        fd_seen  = 0;
        send_run(0, 17, 0);
        check_eq("no_win_before_18", win_valid, 0);
        send_run(18, 18, 0);
        check_eq("first_win_valid", win_valid, 1);
        check_eq("first_win", win_out, win_of(0));
        send_run(19, 23, 0);
        send_run(24, 24, 0);
        check_eq("wrap24", win_valid, 0);
        send_run(25, 25, 0);
        check_eq("wrap25", win_valid, 0);
        send_run(26, 26, 0);
        check_eq("win26", win_out, win_of(8));
        send_run(27, 47, 0);
        check_eq("win_count", win_seen, 24);
        check_eq("frame_done_count", fd_seen, 1);

        // Back-pressure after the window for pixel 20
        send_run(0, 20, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, DW'(21), 1'b0, 1'b0);
            check_eq("stall_hold", win_out, win_of(2));
        end
        send_run(21, 21, 0);
        check_eq("after_stall_win21", win_out, win_of(3));
        send_run(22, 47, 0);

        // Reset mid-frame, then a fresh frame offset by 100
        send_run(0, 20, 0);
        do_reset();
        send_run(0, 17, 100);
        check_eq("new_frame_quiet", win_valid, 0);
        send_run(18, 18, 100);
        check_eq("new_frame_first", win_out, win_of(100));
        send_run(19, 47, 100);

        // Misplaced SOF on pixel 13
        send_run(0, 12, 0);
        tick(1'b1, DW'(13), 1'b1, 1'b1);
`ifdef CONV_WINDOW_SOF_CHECK_EN
        check_eq("sof13_err", sof_err, 1);
`else
        check_eq("sof13_ignored", sof_err, 0);
`endif
        for (int p = 14; p <= 40; p++) begin
            tick(1'b1, DW'(p), 1'b0, 1'b1);
        end

        // Randomised traffic: gaps, back-pressure, random data and stray SOFs
        do_reset();
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
